// File: rtl/alu_muldiv_seq.sv
// Execute unit: 1-cycle base ALU ops, WIDTH+1-cycle shift-add multiply and, with ALU_MULDIV_DIV_EN, restoring divide.
// Valid/ready on both sides; in_ready is low while iterating and while a result waits for out_ready.
module alu_muldiv_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [4:0]       in_ctl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_illegal
);
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_AUIPC = 4'd10;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t               state, st_state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc, mul_nxt, mul_fin;
  logic [WIDTH-1:0]     opb, mag_a, mag_b, base_res, st_res, mul_res;
  logic [WIDTH:0]       mul_sum;
  logic [SHAMT_W-1:0]   shamt;
  logic [2:0]           f3;
  logic                 neg_q, a_sgn, b_sgn, a_neg, b_neg, base_ill, st_ill, accept;

  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept   = in_valid & in_ready;
  assign shamt    = in_b[SHAMT_W-1:0];

  // Decode of the incoming op: where it goes and what a 1-cycle op returns.
  always_comb begin
    a_sgn = in_ctl[4] & (in_ctl[2:0] == 3'd1 || in_ctl[2:0] == 3'd2 ||
                         in_ctl[2:0] == 3'd4 || in_ctl[2:0] == 3'd6);
    b_sgn = in_ctl[4] & (in_ctl[2:0] == 3'd1 || in_ctl[2:0] == 3'd4 || in_ctl[2:0] == 3'd6);
    a_neg = a_sgn & in_a[WIDTH-1];
    b_neg = b_sgn & in_b[WIDTH-1];
    mag_a = a_neg ? -in_a : in_a;
    mag_b = b_neg ? -in_b : in_b;
    base_res = '0;
    base_ill = 1'b0;
    case (in_ctl[3:0])
      ALU_ADD:   base_res = in_a + in_b;
      ALU_SUB:   base_res = in_a - in_b;
      ALU_SLL:   base_res = in_a << shamt;
      ALU_SLT:   base_res = {{(WIDTH-1){1'b0}}, $signed(in_a) < $signed(in_b)};
      ALU_SLTU:  base_res = {{(WIDTH-1){1'b0}}, in_a < in_b};
      ALU_XOR:   base_res = in_a ^ in_b;
      ALU_SRL:   base_res = in_a >> shamt;
      ALU_SRA:   base_res = $signed(in_a) >>> shamt;
      ALU_OR:    base_res = in_a | in_b;
      ALU_AND:   base_res = in_a & in_b;
      ALU_AUIPC: base_res = in_a + (in_b << 12);
      default:   base_ill = 1'b1;
    endcase
    st_state = DONE;
    st_res   = base_res;
    st_ill   = base_ill;
    if (in_ctl[4]) begin
      st_res = '0;
      st_ill = 1'b0;
      if (!in_ctl[2]) begin
        st_state = MUL;
      end else begin
`ifdef ALU_MULDIV_DIV_EN
        if (in_b == '0)
          st_res = in_ctl[1] ? in_a : '1;
        else if (!in_ctl[0] && in_a == MIN_VAL && in_b == '1)
          st_res = in_ctl[1] ? '0 : MIN_VAL;
        else
          st_state = DIV;
`else
        st_ill = 1'b1;
`endif
      end
    end
  end

  // acc = {partial product high, multiplier bits}; one add-and-shift per cycle.
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    mul_nxt = {mul_sum, acc[WIDTH-1:1]};
    mul_fin = neg_q ? -mul_nxt : mul_nxt;
    mul_res = (f3 == 3'd0) ? mul_fin[WIDTH-1:0] : mul_fin[2*WIDTH-1:WIDTH];
  end

`ifdef ALU_MULDIV_DIV_EN
  logic [WIDTH:0]       div_sh, div_diff;
  logic [2*WIDTH-1:0]   div_nxt;
  logic [WIDTH-1:0]     div_res;
  logic                 neg_r;

  // acc = {partial remainder, dividend/quotient}; quotient bits shift in from the right.
  always_comb begin
    div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff = div_sh - {1'b0, opb};
    div_nxt  = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    div_res  = f3[1] ? (neg_r ? -div_nxt[2*WIDTH-1:WIDTH] : div_nxt[2*WIDTH-1:WIDTH])
                     : (neg_q ? -div_nxt[WIDTH-1:0] : div_nxt[WIDTH-1:0]);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_illegal <= 1'b0;
      acc         <= '0;
      opb         <= '0;
      f3          <= '0;
      neg_q       <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
      neg_r       <= 1'b0;
`endif
    end else if (flush) begin
      state       <= IDLE;
      cnt         <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_illegal <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state       <= st_state;
            out_valid   <= (st_state == DONE);
            out_result  <= st_res;
            out_illegal <= st_ill;
            acc         <= {{WIDTH{1'b0}}, mag_a};
            opb         <= mag_b;
            f3          <= in_ctl[2:0];
            neg_q       <= a_neg ^ b_neg;
            cnt         <= '0;
`ifdef ALU_MULDIV_DIV_EN
            neg_r       <= a_neg;
`endif
          end else if (state == DONE && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        // The last iteration and the sign fix-up share the cycle the counter reaches WIDTH.
        MUL: begin
          acc <= mul_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            out_result  <= mul_res;
            out_illegal <= 1'b0;
          end
        end
        DIV: begin
`ifdef ALU_MULDIV_DIV_EN
          acc <= div_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            out_result  <= div_res;
            out_illegal <= 1'b0;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed and random checks of alu_muldiv_seq (WIDTH=32) against an arithmetic reference model.
// Expectations follow ALU_MULDIV_DIV_EN the same way the design is built.
module tb_alu_muldiv_seq;
  localparam int W = 32;
`ifdef ALU_MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [W-1:0] in_a, in_b, out_result;
  logic [4:0]   in_ctl;
  int           n_cmp = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ctl(in_ctl), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_illegal(out_illegal)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: results from plain arithmetic on the RV32M rules.
  function automatic void model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic il, output int lat);
    logic [63:0] p;
    r = '0; il = 1'b0; lat = 1;
    if (!c[4]) begin
      case (c[3:0])
        4'd0:  r = a + b;
        4'd1:  r = a - b;
        4'd2:  r = a << b[4:0];
        4'd3:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        4'd4:  r = (a < b) ? 32'd1 : 32'd0;
        4'd5:  r = a ^ b;
        4'd6:  r = a >> b[4:0];
        4'd7:  r = $signed(a) >>> b[4:0];
        4'd8:  r = a | b;
        4'd9:  r = a & b;
        4'd10: r = a + (b << 12);
        default: il = 1'b1;
      endcase
    end else if (!c[2]) begin
      lat = W + 1;
      case (c[1:0])
        2'd0: p = {32'b0, a} * {32'b0, b};
        2'd1: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        2'd2: p = {{32{a[31]}}, a} * {32'b0, b};
        default: p = {32'b0, a} * {32'b0, b};
      endcase
      r = (c[1:0] == 2'd0) ? p[31:0] : p[63:32];
    end else if (!DIV_EN) begin
      il = 1'b1;
    end else if (b == 0) begin
      r = c[1] ? a : 32'hFFFF_FFFF;
    end else if (!c[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = c[1] ? 32'd0 : 32'h8000_0000;
    end else begin
      lat = W + 1;
      case (c[1:0])
        2'd0: r = $signed(a) / $signed(b);
        2'd1: r = a / b;
        2'd2: r = $signed(a) % $signed(b);
        default: r = a % b;
      endcase
    end
  endfunction

  task automatic run_op(input string tag, input logic [4:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic ei, input int el);
    int   lat;
    logic rdy_hi;
    in_ctl = c; in_a = a; in_b = b; in_valid = 1'b1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_ctl = 5'($urandom);
    lat = 1; rdy_hi = 1'b0;
    while (out_valid !== 1'b1 && lat < 200) begin
      if (in_ready) rdy_hi = 1'b1;
      step();
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(el));
    chk({tag, ".result"}, out_result, er);
    chk({tag, ".illegal"}, 32'(out_illegal), 32'(ei));
    if (el > 1) chk({tag, ".busy"}, 32'(rdy_hi), 32'd0);
    step();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, a, b;
    logic        il, seen;
    logic [4:0]  c;
    int          lat;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_ctl = '0;
    #2;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_result", out_result, 32'd0);
    chk("rst.out_illegal", 32'(out_illegal), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    step();

    run_op("add_wrap", 5'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1);
    run_op("sltu", 5'd4, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1);
    run_op("undef_base", 5'd13, 32'd5, 32'd6, 32'd0, 1'b1, 1);
    run_op("mul_lo", 5'b10000, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 33);
    run_op("mulhu", 5'b10011, 32'h0001_0000, 32'h0001_0000, 32'd1, 1'b0, 33);
    run_op("mulh", 5'b10001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 33);
    run_op("div_neg", 5'b10100, 32'hFFFF_FFF9, 32'd2, DIV_EN ? 32'hFFFF_FFFD : 32'd0, !DIV_EN, DIV_EN ? 33 : 1);
    run_op("rem_neg", 5'b10110, 32'hFFFF_FFF9, 32'd2, DIV_EN ? 32'hFFFF_FFFF : 32'd0, !DIV_EN, DIV_EN ? 33 : 1);
    run_op("div_by0", 5'b10100, 32'd7, 32'd0, DIV_EN ? 32'hFFFF_FFFF : 32'd0, !DIV_EN, 1);
    run_op("rem_by0", 5'b10110, 32'd7, 32'd0, DIV_EN ? 32'd7 : 32'd0, !DIV_EN, 1);
    run_op("div_ovf", 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, DIV_EN ? 32'h8000_0000 : 32'd0, !DIV_EN, 1);
    run_op("rem_ovf", 5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, !DIV_EN, 1);
    run_op("divu", 5'b10101, 32'd9, 32'd3, DIV_EN ? 32'd3 : 32'd0, !DIV_EN, DIV_EN ? 33 : 1);
    run_op("mul_small", 5'b10000, 32'd3, 32'd4, 32'd12, 1'b0, 33);

    // Result held under backpressure, then a new op taken on the release edge.
    out_ready = 1'b0;
    in_ctl = 5'd0; in_a = 32'd2; in_b = 32'd3; in_valid = 1'b1;
    step();
    in_ctl = 5'd1; in_a = 32'd10; in_b = 32'd3;
    repeat (5) begin
      chk("hold.out_valid", 32'(out_valid), 32'd1);
      chk("hold.out_result", out_result, 32'd5);
      chk("hold.in_ready", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("release.in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("release.out_valid", 32'(out_valid), 32'd1);
    chk("release.out_result", out_result, 32'd7);
    step();
    chk("release.drained", 32'(out_valid), 32'd0);

    // Flush ten iterations into a multiply, with a competing in_valid.
    in_ctl = 5'b10000; in_a = 32'd1234; in_b = 32'd5678; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    flush = 1'b1; in_valid = 1'b1; in_ctl = 5'd0; in_a = 32'd1; in_b = 32'd1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    chk("flush.in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (40) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      step();
    end
    chk("flush.no_result", 32'(seen), 32'd0);
    run_op("after_flush", 5'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1);

    // Asynchronous reset in the middle of a divide.
    in_ctl = 5'b10101; in_a = 32'd100; in_b = 32'd7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk("arst.out_valid", 32'(out_valid), 32'd0);
    chk("arst.in_ready", 32'(in_ready), 32'd1);
    chk("arst.out_result", out_result, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      step();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    chk("arst.no_result", 32'(seen), 32'd0);
    run_op("after_arst", 5'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1);

    for (int i = 0; i < 80; i++) begin
      c = 5'($urandom);
      a = pick();
      b = pick();
      model(c, a, b, r, il, lat);
      run_op($sformatf("rnd%0d_ctl%02h", i, c), c, a, b, r, il, lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
